// File: rtl/antilog_pkg.sv
// rtl/antilog_pkg.sv - shared widths, stage payload and reference conversion for antilog_pipe
package antilog_pkg;

    localparam int DEF_EXP_W  = 4;
    localparam int DEF_FRAC_W = 7;
    localparam int DEF_MAG_W  = 15;
    localparam int DEF_DQL_W  = DEF_EXP_W + DEF_FRAC_W + 1;
    // Shifted value keeps one guard bit above the largest possible result.
    localparam int DEF_SH_W   = (1 << DEF_EXP_W) + 1;
    localparam int DEF_CH_W   = 5;

    // Payload carried from the first register stage to the converter.
    typedef struct packed {
        logic                 ds;
        logic                 dqs;
        logic [DEF_CH_W-1:0]  ch;
        logic [DEF_SH_W-1:0]  full;
    } antilog_stage_t;

    // Returns {ovf, full} for a DQL at the default widths; negative logs give zero.
    function automatic logic [DEF_SH_W:0] antilog_mag(input logic [DEF_DQL_W-1:0] dql);
        logic [DEF_SH_W-1:0] full;
        full = DEF_SH_W'(({{(DEF_SH_W-1){1'b0}}, 1'b1, dql[DEF_FRAC_W-1:0]}
                          << dql[DEF_DQL_W-2 -: DEF_EXP_W]) >> DEF_FRAC_W);
        if (dql[DEF_DQL_W-1]) begin
            return '0;
        end
        return {(full >= (DEF_SH_W'(1) << DEF_MAG_W)), full};
    endfunction

endpackage

// File: rtl/antilog_core.sv
// rtl/antilog_core.sv - combinational overflow detect, truncate/saturate and sign assembly
module antilog_core
    import antilog_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W,
    parameter int SH_W  = DEF_SH_W,
    parameter int SAT   = 0
) (
    input  logic              ds,
    input  logic              dqs,
    input  logic [SH_W-1:0]   full,
    output logic [MAG_W:0]    dq,
    output logic              ovf
);

    localparam logic [SH_W-1:0] LIMIT = SH_W'(1) << MAG_W;

    logic [MAG_W-1:0] mag;

    // Negative log forces zero magnitude; otherwise truncate or clamp on overflow.
    always_comb begin
        ovf = !ds && (full >= LIMIT);
        if (ds) begin
            mag = '0;
        end else if ((SAT != 0) && ovf) begin
            mag = '1;
        end else begin
            mag = full[MAG_W-1:0];
        end
        dq = {dqs, mag};
    end

endmodule

// File: rtl/antilog_pipe.sv
// rtl/antilog_pipe.sv - two-stage elastic log-to-linear converter with channel tag and overflow count
module antilog_pipe
    import antilog_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int MAG_W  = DEF_MAG_W,
    parameter int NCH    = 32,
    parameter int SAT    = 0,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int DQL_W = EXP_W + FRAC_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DQL_W-1:0]   in_dql,
    input  logic               in_dqs,
    input  logic [CH_W-1:0]    in_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAG_W:0]     out_dq,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_ovf,
    output logic [CNT_W-1:0]   sat_count,
    input  logic               sat_clr
);

    localparam int SH_W   = (1 << EXP_W) + 1;
    localparam int WIDE_W = FRAC_W + SH_W;

    typedef struct packed {
        logic              ds;
        logic              dqs;
        logic [CH_W-1:0]   ch;
        logic [SH_W-1:0]   full;
    } s1_t;

    s1_t              s1_d;
    s1_t              s1_q;
    logic             s1_valid;
    logic             s2_valid;
    logic             s2_ready;
    logic [MAG_W:0]   core_dq;
    logic             core_ovf;

    // S2 can take data when empty or draining; S1 likewise when empty or advancing.
    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    // Split DQL and shift {1,DMN} by the exponent at full width before dropping fraction bits.
    always_comb begin
        s1_d.ds   = in_dql[DQL_W-1];
        s1_d.dqs  = in_dqs;
        s1_d.ch   = in_ch;
        s1_d.full = SH_W'((WIDE_W'({1'b1, in_dql[FRAC_W-1:0]})
                           << in_dql[DQL_W-2 -: EXP_W]) >> FRAC_W);
    end

    antilog_core #(
        .MAG_W (MAG_W),
        .SH_W  (SH_W),
        .SAT   (SAT)
    ) u_core (
        .ds   (s1_q.ds),
        .dqs  (s1_q.dqs),
        .full (s1_q.full),
        .dq   (core_dq),
        .ovf  (core_ovf)
    );

    // Advance both stages; output registers hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            out_dq   <= '0;
            out_ch   <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_dq  <= core_dq;
                    out_ch  <= s1_q.ch;
                    out_ovf <= core_ovf;
                end
            end
        end
    end

    // Count overflow transfers, sticking at all-ones; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_ovf && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_antilog_pipe.sv
// tb/tb_antilog_pipe.sv - scoreboard bench for antilog_pipe (truncating and saturating instances)
module tb_antilog_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_dqs, out_ready, sat_clr;
    logic [11:0] in_dql;
    logic [4:0]  in_ch;

    logic        in_ready0, out_valid0, out_ovf0;
    logic [15:0] out_dq0, sat_count0;
    logic [4:0]  out_ch0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [15:0] out_dq1;
    logic [1:0]  sat_count1;
    logic [4:0]  out_ch1;

    always #5 clk = ~clk;

    antilog_pipe u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_dql(in_dql), .in_dqs(in_dqs), .in_ch(in_ch),
        .out_valid(out_valid0), .out_ready(out_ready), .out_dq(out_dq0),
        .out_ch(out_ch0), .out_ovf(out_ovf0), .sat_count(sat_count0), .sat_clr(sat_clr)
    );

    antilog_pipe #(.SAT(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_dql(in_dql), .in_dqs(in_dqs), .in_ch(in_ch),
        .out_valid(out_valid1), .out_ready(out_ready), .out_dq(out_dq1),
        .out_ch(out_ch1), .out_ovf(out_ovf1), .sat_count(sat_count1), .sat_clr(sat_clr)
    );

    typedef struct {
        logic [15:0] dq0;
        logic [15:0] dq1;
        logic        ovf;
        logic [4:0]  ch;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          cnt0 = 0;
    int          cnt1 = 0;
    bit          lat_mode = 1'b1;
    bit          stall = 1'b0;
    logic [15:0] p_dq0, p_dq1;
    logic [4:0]  p_ch;
    logic        p_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // |DQ| = 2^DEX * (1 + DMN/128) truncated to an integer; negative log means zero.
    function automatic exp_t model(input logic [11:0] dql, input logic dqs, input logic [4:0] ch);
        exp_t   e;
        longint full;
        int     dex, dmn;
        e.ch  = ch;
        e.acc = 0;
        e.lat = 1'b0;
        if (dql[11]) begin
            e.ovf = 1'b0;
            e.dq0 = {dqs, 15'd0};
            e.dq1 = {dqs, 15'd0};
        end else begin
            dex  = int'(dql[10:7]);
            dmn  = int'(dql[6:0]);
            full = ((128 + dmn) * (longint'(1) << dex)) / 128;
            e.ovf = (full >= 32768);
            e.dq0 = {dqs, 15'(full % 32768)};
            e.dq1 = {dqs, e.ovf ? 15'h7FFF : 15'(full)};
        end
        return e;
    endfunction

    // Monitor: occupancy, stall stability, in-order data and counter model, sampled at negedge.
    always @(negedge clk) begin
        exp_t e, ex;
        bit   popped_ovf;
        cyc++;
        popped_ovf = 1'b0;
        if (!rst_n) begin
            q.delete();
            cnt0  = 0;
            cnt1  = 0;
            stall = 1'b0;
        end else begin
            check("sat_count0", sat_count0, cnt0);
            check("sat_count1", sat_count1, cnt1);
            check("in_ready", in_ready0, !(q.size() == 2 && !out_ready));
            check("mirror_valid", {in_ready1, out_valid1}, {in_ready0, out_valid0});
            if (stall) begin
                check("stall_valid", out_valid0, 1);
                check("stall_data", {out_dq0, out_dq1, out_ch0, out_ovf0}, {p_dq0, p_dq1, p_ch, p_ovf});
            end
            if (out_valid0) begin
                check("out_expected", q.size() != 0, 1);
                if (q.size() != 0 && out_ready) begin
                    e = q.pop_front();
                    popped_ovf = e.ovf;
                    check("dq_trunc", out_dq0, e.dq0);
                    check("dq_sat", out_dq1, e.dq1);
                    check("ovf", {out_ovf0, out_ovf1}, {e.ovf, e.ovf});
                    check("ch", {out_ch0, out_ch1}, {e.ch, e.ch});
                    if (e.lat) check("latency", cyc - e.acc, 2);
                end
            end
            stall = out_valid0 && !out_ready;
            p_dq0 = out_dq0;
            p_dq1 = out_dq1;
            p_ch  = out_ch0;
            p_ovf = out_ovf0;
            if (sat_clr) begin
                cnt0 = 0;
                cnt1 = 0;
            end else if (popped_ovf) begin
                if (cnt0 != 65535) cnt0++;
                if (cnt1 != 3) cnt1++;
            end
            if (in_valid && in_ready0) begin
                ex = model(in_dql, in_dqs, in_ch);
                ex.acc = cyc;
                ex.lat = lat_mode;
                q.push_back(ex);
            end
        end
    end

    task automatic drive(input logic v, input logic [11:0] dql, input logic dqs, input logic [4:0] ch);
        @(posedge clk);
        #1;
        in_valid = v;
        in_dql   = dql;
        in_dqs   = dqs;
        in_ch    = ch;
    endtask

    logic [11:0] dir_dql [7] = '{12'h000, 12'h380, 12'h700, 12'h800, 12'hFFF, 12'h7FF, 12'h0FF};
    logic        dir_dqs [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int  sent, c;
        bit  acc;
        rst_n = 1'b0; in_valid = 1'b0; in_dql = '0; in_dqs = 1'b0; in_ch = '0;
        out_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {out_valid0, out_valid1}, 2'b00);
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_dq", out_dq0, 16'h0000);
        check("rst_out_ch_ovf", {out_ch0, out_ovf0}, 6'h00);
        check("rst_sat_count", sat_count0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) drive(1'b1, dir_dql[i], dir_dqs[i], 5'(i));
        drive(1'b0, 12'h000, 1'b0, 5'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sat_after_ovf", sat_count0, 1);
        @(posedge clk);
        #1 sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        @(negedge clk);
        check("sat_cleared", {sat_count0, 14'd0, sat_count1}, 32'd0);

        for (int i = 0; i < 8192; i++)
            drive(1'b1, 12'(i >> 1), i[0], 5'($urandom_range(0, 31)));
        drive(1'b0, 12'h000, 1'b0, 5'd0);
        repeat (4) @(posedge clk);

        lat_mode = 1'b0;
        sent = 0; c = 0; acc = 1'b0;
        while (sent < 10000 && c < 60000) begin
            @(posedge clk);
            if (acc) sent++;
            c++;
            #1;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_dql    = 12'($urandom);
            in_dqs    = 1'($urandom);
            in_ch     = 5'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready0;
        end
        check("random_done", sent, 10000);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);

        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b1; in_dql = 12'h7FF; in_dqs = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_before_reset", {in_ready0, out_valid0}, 2'b01);
        @(posedge clk);
        #1 in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_sat_count", sat_count0, 0);
        check("midrst_in_ready", in_ready0, 1);
        @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1; lat_mode = 1'b1;
        drive(1'b1, 12'h380, 1'b1, 5'd17);
        drive(1'b0, 12'h000, 1'b0, 5'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
